// File: rtl/associative_array_lookup_ctrl.sv
// Lookup controller for a set-associative tag array: reads a set, compares all
// ways, optionally installs the tag on a miss, then returns a one-hot way result.
module associative_array_lookup_ctrl #(
  parameter int TAG_WIDTH             = 16,
  parameter int NUM_SET               = 64,
  parameter int NUM_WAY               = 16,
  parameter int SET_PTR_WIDTH_IN_BITS = $clog2(NUM_SET)
) (
  input  logic                                 clk_in,
  input  logic                                 reset_n_in,
  input  logic                                 request_valid_in,
  output logic                                 request_ready_out,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     request_set_in,
  input  logic [TAG_WIDTH-1:0]                 request_tag_in,
  input  logic                                 request_allocate_in,
  output logic                                 response_valid_out,
  input  logic                                 response_ready_in,
  output logic                                 response_hit_out,
  output logic [NUM_WAY-1:0]                   response_way_out,
  output logic                                 array_access_en_out,
  output logic                                 array_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]     array_set_addr_out,
  output logic [NUM_WAY-1:0]                   array_way_select_out,
  output logic [TAG_WIDTH:0]                   array_write_entry_out,
  input  logic [(TAG_WIDTH+1)*NUM_WAY-1:0]     array_read_set_in,
  output logic [2:0]                           dbg_state_out
);

  localparam int W   = TAG_WIDTH + 1;
  localparam int RRW = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; response outputs stay frozen from valid rising until that edge.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    COMPARE = 3'd2,
    FILL    = 3'd3,
    RESPOND = 3'd4
  } state_t;

  state_t                             r_state;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]   r_set;
  logic [TAG_WIDTH-1:0]               r_tag;
  logic                               r_alloc;
  logic [RRW-1:0]                     r_rr_ptr;
  logic [NUM_WAY-1:0]                 r_victim;
  logic                               r_resp_valid;
  logic                               r_resp_hit;
  logic [NUM_WAY-1:0]                 r_resp_way;
  logic                               r_acc_en;
  logic                               r_wr_en;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]   r_addr;
  logic [NUM_WAY-1:0]                 r_way_sel;
  logic [W-1:0]                       r_wr_entry;

  logic [NUM_WAY-1:0]                 w_hit_oh;
  logic [NUM_WAY-1:0]                 w_free_oh;
  logic                               w_any_hit;
  logic                               w_any_free;
  logic [NUM_WAY-1:0]                 w_victim_oh;

  // Lowest-index priority for both the hit way and the first invalid way.
  always_comb begin : cmp_blk
    logic [W-1:0] v_entry;
    w_hit_oh   = '0;
    w_free_oh  = '0;
    w_any_hit  = 1'b0;
    w_any_free = 1'b0;
    v_entry    = '0;
    for (int i = 0; i < NUM_WAY; i++) begin
      v_entry = array_read_set_in[i*W +: W];
      if (v_entry[W-1] && (v_entry[TAG_WIDTH-1:0] == r_tag) && !w_any_hit) begin
        w_hit_oh[i] = 1'b1;
        w_any_hit   = 1'b1;
      end
      if (!v_entry[W-1] && !w_any_free) begin
        w_free_oh[i] = 1'b1;
        w_any_free   = 1'b1;
      end
    end
    w_victim_oh = w_any_free ? w_free_oh : (NUM_WAY'(1) << r_rr_ptr);
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state      <= IDLE;
      r_set        <= '0;
      r_tag        <= '0;
      r_alloc      <= 1'b0;
      r_rr_ptr     <= '0;
      r_victim     <= '0;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_way   <= '0;
      r_acc_en     <= 1'b0;
      r_wr_en      <= 1'b0;
      r_addr       <= '0;
      r_way_sel    <= '0;
      r_wr_entry   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (request_valid_in) begin
            r_set     <= request_set_in;
            r_tag     <= request_tag_in;
            r_alloc   <= request_allocate_in;
            r_acc_en  <= 1'b1;
            r_wr_en   <= 1'b0;
            r_addr    <= request_set_in;
            r_way_sel <= '1;
            r_state   <= READ;
          end
        end
        READ: begin
          r_acc_en  <= 1'b0;
          r_addr    <= '0;
          r_way_sel <= '0;
          r_state   <= COMPARE;
        end
        COMPARE: begin
          if (w_any_hit) begin
            r_resp_valid <= 1'b1;
            r_resp_hit   <= 1'b1;
            r_resp_way   <= w_hit_oh;
            r_state      <= RESPOND;
          end else if (!r_alloc) begin
            r_resp_valid <= 1'b1;
            r_resp_hit   <= 1'b0;
            r_resp_way   <= '0;
            r_state      <= RESPOND;
          end else begin
            r_victim   <= w_victim_oh;
            r_acc_en   <= 1'b1;
            r_wr_en    <= 1'b1;
            r_addr     <= r_set;
            r_way_sel  <= w_victim_oh;
            r_wr_entry <= {1'b1, r_tag};
            // The pointer only moves when it actually chose the victim.
            if (!w_any_free) begin
              r_rr_ptr <= (r_rr_ptr == RRW'(NUM_WAY-1)) ? '0 : r_rr_ptr + RRW'(1);
            end
            r_state    <= FILL;
          end
        end
        FILL: begin
          r_acc_en     <= 1'b0;
          r_wr_en      <= 1'b0;
          r_addr       <= '0;
          r_way_sel    <= '0;
          r_wr_entry   <= '0;
          r_resp_valid <= 1'b1;
          r_resp_hit   <= 1'b0;
          r_resp_way   <= r_victim;
          r_state      <= RESPOND;
        end
        RESPOND: begin
          if (response_ready_in) begin
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_way   <= '0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Ready is gated by reset so it reads 0 while reset is held.
  assign request_ready_out     = (r_state == IDLE) && reset_n_in;
  assign response_valid_out    = r_resp_valid;
  assign response_hit_out      = r_resp_hit;
  assign response_way_out      = r_resp_way;
  assign array_access_en_out   = r_acc_en;
  assign array_write_en_out    = r_wr_en;
  assign array_set_addr_out    = r_addr;
  assign array_way_select_out  = r_way_sel;
  assign array_write_entry_out = r_wr_entry;
  assign dbg_state_out         = r_state;

endmodule

// File: tb/tb_associative_array_lookup_ctrl.sv
// Directed bench for associative_array_lookup_ctrl with a 4-way, 8-bit-tag array
// model that returns read data one cycle after the access.
module tb_associative_array_lookup_ctrl;

  localparam int TW = 8;
  localparam int NW = 4;
  localparam int NS = 64;
  localparam int SW = 6;
  localparam int W  = TW + 1;

  logic            clk_in;
  logic            reset_n_in;
  logic            request_valid_in;
  logic            request_ready_out;
  logic [SW-1:0]   request_set_in;
  logic [TW-1:0]   request_tag_in;
  logic            request_allocate_in;
  logic            response_valid_out;
  logic            response_ready_in;
  logic            response_hit_out;
  logic [NW-1:0]   response_way_out;
  logic            array_access_en_out;
  logic            array_write_en_out;
  logic [SW-1:0]   array_set_addr_out;
  logic [NW-1:0]   array_way_select_out;
  logic [TW:0]     array_write_entry_out;
  logic [W*NW-1:0] array_read_set_in;
  logic [2:0]      dbg_state_out;

  int n_checks = 0;
  int n_errors = 0;

  associative_array_lookup_ctrl #(
    .TAG_WIDTH(TW), .NUM_SET(NS), .NUM_WAY(NW)
  ) dut (
    .clk_in(clk_in),
    .reset_n_in(reset_n_in),
    .request_valid_in(request_valid_in),
    .request_ready_out(request_ready_out),
    .request_set_in(request_set_in),
    .request_tag_in(request_tag_in),
    .request_allocate_in(request_allocate_in),
    .response_valid_out(response_valid_out),
    .response_ready_in(response_ready_in),
    .response_hit_out(response_hit_out),
    .response_way_out(response_way_out),
    .array_access_en_out(array_access_en_out),
    .array_write_en_out(array_write_en_out),
    .array_set_addr_out(array_set_addr_out),
    .array_way_select_out(array_way_select_out),
    .array_write_entry_out(array_write_entry_out),
    .array_read_set_in(array_read_set_in),
    .dbg_state_out(dbg_state_out)
  );

  // clock / reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // array model with clear and direct preload ports
  logic [W-1:0]  mem [NS][NW];
  logic          mem_clr;
  logic          pre_en;
  logic [SW-1:0] pre_set;
  int            pre_way;
  logic [W-1:0]  pre_val;

  always @(posedge clk_in) begin
    if (mem_clr) begin
      for (int s = 0; s < NS; s++)
        for (int w = 0; w < NW; w++) mem[s][w] <= '0;
    end else if (pre_en) begin
      mem[pre_set][pre_way] <= pre_val;
    end else if (array_access_en_out) begin
      if (array_write_en_out) begin
        for (int w = 0; w < NW; w++)
          if (array_way_select_out[w]) mem[array_set_addr_out][w] <= array_write_entry_out;
      end else begin
        for (int w = 0; w < NW; w++) array_read_set_in[w*W +: W] <= mem[array_set_addr_out][w];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [SW-1:0] s, input int w, input logic [W-1:0] v);
    @(negedge clk_in);
    pre_en = 1'b1; pre_set = s; pre_way = w; pre_val = v;
    @(negedge clk_in);
    pre_en = 1'b0;
  endtask

  // One request: checks latency, result, write activity, optional backpressure.
  task automatic run_req(input string nm, input logic [SW-1:0] s, input logic [TW-1:0] t,
                         input logic alloc, input logic exp_hit, input logic [NW-1:0] exp_way,
                         input int exp_lat, input logic exp_wr, input logic [NW-1:0] exp_wsel,
                         input int bp);
    int lat;
    logic wrote, seen, h0;
    logic [NW-1:0] wsel, w0;
    logic [W-1:0] went;
    lat = 0; wrote = 1'b0; seen = 1'b0; wsel = '0; went = '0;
    @(negedge clk_in);
    chk({nm, " req_ready"}, 32'(request_ready_out), 32'd1);
    request_valid_in = 1'b1; request_set_in = s; request_tag_in = t; request_allocate_in = alloc;
    @(posedge clk_in);
    #1;
    request_valid_in = 1'b0; request_set_in = ~s; request_tag_in = ~t; request_allocate_in = ~alloc;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk_in);
      if (array_write_en_out) begin
        wrote = 1'b1; wsel = array_way_select_out; went = array_write_entry_out;
      end
      if (response_valid_out) begin
        seen = 1'b1; lat = c;
      end
    end
    if (!seen) begin
      chk({nm, " timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " hit"}, 32'(response_hit_out), 32'(exp_hit));
    chk({nm, " way"}, 32'(response_way_out), 32'(exp_way));
    chk({nm, " wrote"}, 32'(wrote), 32'(exp_wr));
    if (exp_wr) begin
      chk({nm, " wsel"}, 32'(wsel), 32'(exp_wsel));
      chk({nm, " wentry"}, 32'(went), 32'({1'b1, t}));
    end
    h0 = response_hit_out; w0 = response_way_out;
    for (int k = 1; k < bp; k++) begin
      @(negedge clk_in);
      chk({nm, " bp valid"}, 32'(response_valid_out), 32'd1);
      chk({nm, " bp hold"}, 32'({response_hit_out, response_way_out}), 32'({h0, w0}));
      chk({nm, " bp req_ready"}, 32'(request_ready_out), 32'd0);
    end
    if (bp > 0) @(negedge clk_in);
    response_ready_in = 1'b1;
    @(posedge clk_in);
    #1;
    response_ready_in = 1'b0;
    if (bp > 0) begin
      @(negedge clk_in);
      chk({nm, " post-hs req_ready"}, 32'(request_ready_out), 32'd1);
      chk({nm, " post-hs valid"}, 32'(response_valid_out), 32'd0);
    end
  endtask

  initial begin
    bit fill_seen;
    reset_n_in = 1'b0; mem_clr = 1'b1; pre_en = 1'b0; pre_set = '0; pre_way = 0; pre_val = '0;
    request_valid_in = 1'b0; request_set_in = '0; request_tag_in = '0; request_allocate_in = 1'b0;
    response_ready_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst req_ready", 32'(request_ready_out), 32'd0);
    chk("rst outputs", 32'({response_valid_out, response_hit_out, response_way_out,
                             array_access_en_out, array_write_en_out, array_way_select_out}), 32'd0);
    chk("rst entry", 32'(array_write_entry_out), 32'd0);
    chk("rst state", 32'(dbg_state_out), 32'd0);
    @(negedge clk_in);
    reset_n_in = 1'b1; mem_clr = 1'b0;
    @(negedge clk_in);
    chk("post-rst req_ready", 32'(request_ready_out), 32'd1);

    run_req("cold alloc", 6'd5, 8'h3A, 1'b1, 1'b0, 4'b0001, 4, 1'b1, 4'b0001, 0);
    run_req("repeat hit", 6'd5, 8'h3A, 1'b1, 1'b1, 4'b0001, 3, 1'b0, 4'b0000, 0);
    run_req("fill 3B",    6'd5, 8'h3B, 1'b1, 1'b0, 4'b0010, 4, 1'b1, 4'b0010, 0);
    run_req("fill 3C",    6'd5, 8'h3C, 1'b1, 1'b0, 4'b0100, 4, 1'b1, 4'b0100, 0);
    run_req("fill 3D",    6'd5, 8'h3D, 1'b1, 1'b0, 4'b1000, 4, 1'b1, 4'b1000, 0);
    run_req("rr 3E",      6'd5, 8'h3E, 1'b1, 1'b0, 4'b0001, 4, 1'b1, 4'b0001, 0);
    run_req("rr 3F",      6'd5, 8'h3F, 1'b1, 1'b0, 4'b0010, 4, 1'b1, 4'b0010, 0);
    run_req("evicted 3A", 6'd5, 8'h3A, 1'b0, 1'b0, 4'b0000, 3, 1'b0, 4'b0000, 0);
    run_req("miss noalloc", 6'd9, 8'h77, 1'b0, 1'b0, 4'b0000, 3, 1'b0, 4'b0000, 0);
    run_req("backpressure", 6'd5, 8'h3C, 1'b0, 1'b1, 4'b0100, 3, 1'b0, 4'b0000, 5);

    // set 7: way0 other tag, way1/3 valid 42, way2 invalid 42
    preload(6'd7, 0, 9'h111);
    preload(6'd7, 1, 9'h142);
    preload(6'd7, 2, 9'h042);
    preload(6'd7, 3, 9'h142);
    run_req("multi hit",  6'd7, 8'h42, 1'b0, 1'b1, 4'b0010, 3, 1'b0, 4'b0000, 0);
    run_req("free victim", 6'd7, 8'h50, 1'b1, 1'b0, 4'b0100, 4, 1'b1, 4'b0100, 0);

    // reset during FILL (round-robin pointer is 2 at this point)
    @(negedge clk_in);
    request_valid_in = 1'b1; request_set_in = 6'd20; request_tag_in = 8'h55; request_allocate_in = 1'b1;
    @(posedge clk_in);
    #1;
    request_valid_in = 1'b0;
    fill_seen = 1'b0;
    for (int c = 0; c < 10 && !fill_seen; c++) begin
      @(negedge clk_in);
      if (array_write_en_out) fill_seen = 1'b1;
    end
    chk("midfill reached", 32'(fill_seen), 32'd1);
    #1 reset_n_in = 1'b0;
    #1;
    chk("midfill wr_en", 32'(array_write_en_out), 32'd0);
    chk("midfill acc_en", 32'(array_access_en_out), 32'd0);
    chk("midfill req_ready", 32'(request_ready_out), 32'd0);
    @(negedge clk_in);
    reset_n_in = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_in);
      chk("post-midfill valid", 32'(response_valid_out), 32'd0);
      chk("post-midfill req_ready", 32'(request_ready_out), 32'd1);
    end
    chk("midfill no write", 32'(mem[20][0]), 32'd0);
    run_req("after reset miss", 6'd20, 8'h55, 1'b0, 1'b0, 4'b0000, 3, 1'b0, 4'b0000, 0);
    run_req("rr reset", 6'd5, 8'h40, 1'b1, 1'b0, 4'b0001, 4, 1'b1, 4'b0001, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/associative_array_lookup_ctrl.md
ASSOCIATIVE_ARRAY_LOOKUP_CTRL -- requirements
Module: associative_array_lookup_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): TAG_WIDTH, 16, tag bits per entry; NUM_SET, 64, sets in the array; NUM_WAY, 16, ways per set; SET_PTR_WIDTH_IN_BITS, $clog2(NUM_SET), set index width.
REQ-002 The block SHALL use an array entry width of TAG_WIDTH+1 bits, laid out as {valid, tag} with valid in the MSB.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- clk_in, input, 1, clock.
- reset_n_in, input, 1, asynchronous active-low reset.
- request_valid_in, input, 1, lookup request present.
- request_ready_out, output, 1, block can accept a request.
- request_set_in, input, SET_PTR_WIDTH_IN_BITS, set index.
- request_tag_in, input, TAG_WIDTH, tag to match.
- request_allocate_in, input, 1, install the tag on a miss.
- response_valid_out, output, 1, result available.
- response_ready_in, input, 1, consumer accepts the result.
- response_hit_out, output, 1, tag matched a valid entry.
- response_way_out, output, NUM_WAY, one-hot hit or filled way; zero on a miss without allocate.
- array_access_en_out, output, 1, array access enable.
- array_write_en_out, output, 1, array write enable.
- array_set_addr_out, output, SET_PTR_WIDTH_IN_BITS, array set address.
- array_way_select_out, output, NUM_WAY, array way select.
- array_write_entry_out, output, TAG_WIDTH+1, entry to write.
- array_read_set_in, input, (TAG_WIDTH+1)*NUM_WAY, all ways of the read set; way i is at bits [(i+1)*W-1 : i*W]; the data arrives one cycle after the access.

Function
REQ-005 The block SHALL implement a state machine with states IDLE, READ, COMPARE, FILL and RESPOND.
REQ-006 request_ready_out SHALL be 1 only in IDLE; a request is accepted when request_valid_in and request_ready_out are both 1 at a clock edge.
REQ-007 On acceptance the block SHALL capture set, tag and allocate into internal registers and move IDLE->READ; later changes on the request inputs SHALL have no effect.
REQ-008 In READ the block SHALL drive access_en=1, write_en=0, way_select=all ones and set_addr=captured set, then move to COMPARE.
REQ-009 In COMPARE the block SHALL sample array_read_set_in; a hit is a way with valid=1 and tag equal to the captured tag.
REQ-010 If more than one way hits, the lowest-index way SHALL win.
REQ-011 Transitions from COMPARE:
- hit -> RESPOND with hit=1 and the one-hot winning way.
- miss with allocate=0 -> RESPOND with hit=0 and way=0.
- miss with allocate=1 -> FILL.
REQ-012 Victim selection SHALL pick the lowest-index way whose valid=0; if every way is valid, it SHALL pick the way given by the round-robin pointer.
REQ-013 In FILL the block SHALL, for one cycle, drive access_en=1, write_en=1, the captured set, way_select=one-hot victim and write_entry={1'b1, captured tag}.
REQ-014 From FILL the block SHALL move to RESPOND with hit=0 and way=victim.
REQ-015 The round-robin pointer SHALL advance by 1, wrapping from NUM_WAY-1 to 0, only when it supplied the victim.
REQ-016 In RESPOND, response_valid_out SHALL be 1 and the response outputs SHALL be held stable until response_ready_in=1; the block then moves to IDLE.
REQ-017 Latency SHALL be counted from the acceptance edge to the first cycle with response_valid_out=1: 3 cycles for a hit or a miss without allocate, 4 cycles for a miss with allocate.
REQ-018 A new request SHALL NOT be accepted in the same cycle as a response handshake; the earliest next acceptance is the edge after the return to IDLE.
REQ-019 Outside READ and FILL, all array_* outputs SHALL be 0.
REQ-020 The block SHALL never clear or initialise array contents itself.

Reset
REQ-021 While reset_n_in=0, the block SHALL asynchronously force state=IDLE and the round-robin pointer to 0.
REQ-022 While reset_n_in=0, every output SHALL be 0, including request_ready_out; request_ready_out SHALL be 1 in the first cycle after reset release.
REQ-023 Reset asserted in any state, including FILL, SHALL drop array_write_en_out immediately; the transaction in progress SHALL be discarded with no response.

Verification
REQ-024 With NUM_WAY=4, TAG_WIDTH=8 and all entries invalid, the bench SHALL cover these directed scenarios:
- Cold allocate: set 5, tag 8'h3A, allocate=1 -> FILL writes way_select 4'b0001, entry 9'h13A; response hit=0, way 4'b0001; response_valid_out=1 four cycles after acceptance.
- Repeat hit: same request again -> hit=1, way 4'b0001; no write cycle; latency 3.
- Round-robin replacement: fill set 5 with tags 3A, 3B, 3C, 3D, then miss on 3E with allocate -> victim 4'b0001; a further miss on 3F -> victim 4'b0010.
- Miss without allocate: set 9, tag 8'h77, allocate=0 -> array_write_en_out never 1; hit=0, way 4'b0000.
- Backpressure: response_ready_in=0 for 5 cycles -> response_valid_out and the response outputs stay constant and request_ready_out=0 throughout; the handshake on cycle 6 leads to request_ready_out=1 on the next cycle.
- Reset mid-FILL: reset_n_in=0 during FILL -> array_write_en_out=0 within the same cycle; after release no response appears and request_ready_out=1.
